// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Requester, response and memory-side bundle of the block-wide
//               main-memory port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int BLOCK_SIZE = 8,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]                       req_cs;
    logic [NUM_REQ-1:0]                       req_rw;
    logic [NUM_REQ*ADDR_WIDTH-1:0]            req_addr;
    logic [NUM_REQ*BLOCK_SIZE*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]                       resp_ack;
    logic [BLOCK_SIZE*DATA_WIDTH-1:0]         resp_data;
    logic                                     mem_cs;
    logic                                     mem_rw;
    logic [ADDR_WIDTH-1:0]                    mem_addr;
    logic [BLOCK_SIZE*DATA_WIDTH-1:0]         mem_data;
    logic                                     mem_ack;
    logic [BLOCK_SIZE*DATA_WIDTH-1:0]         mem_rdata;
    logic                                     busy;
    logic [ID_WIDTH-1:0]                      grant_id;

    // Arbiter side: serves the requesters, masters the memory port.
    modport slave (
        input  req_cs, req_rw, req_addr, req_data, mem_ack, mem_rdata,
        output resp_ack, resp_data, mem_cs, mem_rw, mem_addr, mem_data,
        output busy, grant_id
    );

    // Environment side: requesters plus memory controller.
    modport master (
        output req_cs, req_rw, req_addr, req_data, mem_ack, mem_rdata,
        input  resp_ack, resp_data, mem_cs, mem_rw, mem_addr, mem_data,
        input  busy, grant_id
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Round-robin arbiter sharing one block-wide memory port among
//               NUM_REQ cache controllers; all outputs registered.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int BLOCK_SIZE = 8,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.slave  bus
);
    localparam int c_BLOCK_BITS = BLOCK_SIZE * DATA_WIDTH;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]              r_state;
    logic [ID_WIDTH-1:0]     r_rr_ptr;
    logic [ID_WIDTH-1:0]     r_grant_id;
    logic                    r_mem_cs;
    logic                    r_mem_rw;
    logic [ADDR_WIDTH-1:0]   r_mem_addr;
    logic [c_BLOCK_BITS-1:0] r_mem_data;
    logic [NUM_REQ-1:0]      r_resp_ack;
    logic [c_BLOCK_BITS-1:0] r_resp_data;
    logic                    r_busy;

    logic [ID_WIDTH-1:0]     w_winner;
    logic                    w_any_req;
    logic [ADDR_WIDTH-1:0]   w_addr_arr [NUM_REQ];
    logic [c_BLOCK_BITS-1:0] w_data_arr [NUM_REQ];

    function automatic logic [ID_WIDTH-1:0] wrap_idx(input logic [ID_WIDTH-1:0] base,
                                                     input int off);
        return ID_WIDTH'((int'(base) + off) % NUM_REQ);
    endfunction

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_addr_arr[gi] = bus.req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_data_arr[gi] = bus.req_data[gi*c_BLOCK_BITS +: c_BLOCK_BITS];
        end
    endgenerate

    // Scan from the far end back toward r_rr_ptr so the closest requester wins.
    always_comb begin
        w_winner = r_rr_ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req_cs[wrap_idx(r_rr_ptr, k)]) begin
                w_winner = wrap_idx(r_rr_ptr, k);
            end
        end
    end

    assign w_any_req = |bus.req_cs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_grant_id  <= '0;
            r_mem_cs    <= 1'b0;
            r_mem_rw    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_data  <= '0;
            r_resp_ack  <= '0;
            r_resp_data <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_resp_ack <= '0;
                    if (w_any_req) begin
                        r_grant_id <= w_winner;
                        r_rr_ptr   <= wrap_idx(w_winner, 1);
                        r_mem_rw   <= bus.req_rw[w_winner];
                        r_mem_addr <= w_addr_arr[w_winner];
                        r_mem_data <= w_data_arr[w_winner];
                        r_mem_cs   <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (bus.mem_ack) begin
                        // Write-backs leave the previous read block on resp_data.
                        if (!r_mem_rw) begin
                            r_resp_data <= bus.mem_rdata;
                        end
                        r_mem_cs   <= 1'b0;
                        r_resp_ack <= NUM_REQ'(1) << r_grant_id;
                        r_state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_resp_ack <= '0;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_resp_ack <= '0;
                    r_mem_cs   <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_cs    = r_mem_cs;
    assign bus.mem_rw    = r_mem_rw;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_data  = r_mem_data;
    assign bus.resp_ack  = r_resp_ack;
    assign bus.resp_data = r_resp_data;
    assign bus.busy      = r_busy;
    assign bus.grant_id  = r_grant_id;
endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed, self-checking bench for mem_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;
    localparam int NR = 4;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int BS = 8;
    localparam int BB = BS * DW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass  = 0;
    int   n_total = 0;

    mem_port_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BLOCK_SIZE(BS)) bus ();

    mem_port_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BLOCK_SIZE(BS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [BB-1:0] act, input logic [BB-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [BB-1:0] mk_block(input logic [DW-1:0] base);
        logic [BB-1:0] b;
        for (int w = 0; w < BS; w++) b[w*DW +: DW] = base + DW'(w);
        return b;
    endfunction

    function automatic int rr_pick(input logic [NR-1:0] req, input int ptr);
        for (int k = 0; k < NR; k++) if (req[(ptr + k) % NR]) return (ptr + k) % NR;
        return -1;
    endfunction

    // Transaction-level reference: 0 = waiting, 1 = memory owned, 2 = completion cycle.
    int            m_phase = 0;
    int            m_ptr   = 0;
    int            m_gid   = 0;
    logic          m_rw    = 1'b0;
    logic [AW-1:0] m_addr  = '0;
    logic [BB-1:0] m_wdata = '0;
    logic [BB-1:0] m_rdata = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0; m_ptr <= 0; m_gid <= 0;
            m_rw <= 1'b0; m_addr <= '0; m_wdata <= '0; m_rdata <= '0;
        end else if (m_phase == 0) begin
            if (rr_pick(bus.req_cs, m_ptr) >= 0) begin
                m_gid   <= rr_pick(bus.req_cs, m_ptr);
                m_ptr   <= (rr_pick(bus.req_cs, m_ptr) + 1) % NR;
                m_rw    <= bus.req_rw[rr_pick(bus.req_cs, m_ptr)];
                m_addr  <= bus.req_addr[rr_pick(bus.req_cs, m_ptr)*AW +: AW];
                m_wdata <= bus.req_data[rr_pick(bus.req_cs, m_ptr)*BB +: BB];
                m_phase <= 1;
            end
        end else if (m_phase == 1) begin
            if (bus.mem_ack) begin
                if (!m_rw) m_rdata <= bus.mem_rdata;
                m_phase <= 2;
            end
        end else begin
            m_phase <= 0;
        end
    end

    always @(negedge clk) begin
        chk("mem_cs",    BB'(bus.mem_cs),    BB'(m_phase == 1));
        chk("busy",      BB'(bus.busy),      BB'(m_phase != 0));
        chk("resp_ack",  BB'(bus.resp_ack),  (m_phase == 2) ? BB'(1) << m_gid : '0);
        chk("grant_id",  BB'(bus.grant_id),  BB'(m_gid));
        chk("mem_rw",    BB'(bus.mem_rw),    BB'(m_rw));
        chk("mem_addr",  BB'(bus.mem_addr),  BB'(m_addr));
        chk("mem_data",  bus.mem_data,       m_wdata);
        chk("resp_data", bus.resp_data,      m_rdata);
    end

    task automatic wait_busy(output int cnt);
        cnt = 0;
        while (!bus.mem_cs && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        if (!bus.mem_cs) chk("timeout_mem_cs", 0, 1);
    endtask

    task automatic pulse_ack(input int lat, input logic [BB-1:0] rd);
        repeat (lat - 1) @(negedge clk);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rd;
        @(negedge clk);
        bus.mem_ack   = 1'b0;
    endtask

    initial begin
        int            cnt;
        int            order [5] = '{0, 1, 2, 3, 0};
        logic [BB-1:0] last_read;
        logic [BB-1:0] wblk;

        bus.req_cs = '0; bus.req_rw = '0; bus.req_addr = '0; bus.req_data = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_mem_cs",   BB'(bus.mem_cs),   0);
        chk("rst_busy",     BB'(bus.busy),     0);
        chk("rst_resp_ack", BB'(bus.resp_ack), 0);
        chk("rst_grant_id", BB'(bus.grant_id), 0);
        rst_n = 1'b1;

        // Single read from requester 0
        bus.req_cs = 4'b0001;
        bus.req_addr[0*AW +: AW] = 12'h120;
        wait_busy(cnt);
        chk("t1_grant_lat", BB'(cnt), 1);
        chk("t1_mem_addr",  BB'(bus.mem_addr), 12'h120);
        pulse_ack(3, mk_block(32'hA0));
        chk("t1_resp_ack", BB'(bus.resp_ack), 4'b0001);
        chk("t1_word3",    BB'(bus.resp_data[3*DW +: DW]), 32'hA3);
        chk("t1_cs_done",  BB'(bus.mem_cs), 0);
        bus.req_cs = '0;
        @(negedge clk);
        chk("t1_ack_len",  BB'(bus.resp_ack), 0);

        // Restart pointer at 0, then all four requesters contend
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NR; i++) bus.req_addr[i*AW +: AW] = AW'(12'h100 * (i + 1));
        bus.req_cs = 4'b1111;
        last_read = '0;
        for (int g = 0; g < 5; g++) begin
            wait_busy(cnt);
            if (g > 0) chk("t2_b2b_gap", BB'(cnt), 2);
            last_read = mk_block(32'h1000 * (g + 1));
            pulse_ack(1 + g % 3, last_read);
            chk("t2_grant_id", BB'(bus.grant_id), BB'(order[g]));
            chk("t2_resp_ack", BB'(bus.resp_ack), BB'(1) << order[g]);
            if (g == 4) bus.req_cs = '0;
        end

        // Write-back from requester 2
        wblk = mk_block(32'h5555_0000);
        bus.req_rw = 4'b0100;
        bus.req_addr[2*AW +: AW] = 12'hFE0;
        bus.req_data[2*BB +: BB] = wblk;
        bus.req_cs = 4'b0100;
        wait_busy(cnt);
        chk("t3_mem_rw",   BB'(bus.mem_rw), 1);
        chk("t3_mem_data", bus.mem_data, wblk);
        pulse_ack(2, mk_block(32'hDEAD_0000));
        chk("t3_resp_ack",  BB'(bus.resp_ack), 4'b0100);
        chk("t3_resp_hold", bus.resp_data, last_read);
        bus.req_cs = '0;
        bus.req_rw = '0;

        // Requester 1 changes its address while owning the port
        bus.req_addr[1*AW +: AW] = 12'h040;
        bus.req_cs = 4'b0010;
        wait_busy(cnt);
        bus.req_addr[1*AW +: AW] = 12'h080;
        repeat (2) begin
            @(negedge clk);
            chk("t4_addr_hold", BB'(bus.mem_addr), 12'h040);
        end
        pulse_ack(1, mk_block(32'h0404_0000));
        chk("t4_resp_ack",  BB'(bus.resp_ack), 4'b0010);
        chk("t4_addr_done", BB'(bus.mem_addr), 12'h040);
        bus.req_cs = '0;

        // Stray memory ack while idle
        repeat (2) @(negedge clk);
        pulse_ack(1, mk_block(32'hBAD0_0000));
        chk("t5_no_ack",  BB'(bus.resp_ack), 0);
        chk("t5_no_busy", BB'(bus.busy), 0);
        chk("t5_no_cs",   BB'(bus.mem_cs), 0);

        // Reset two cycles into a transaction
        bus.req_addr[0*AW +: AW] = 12'h2A0;
        bus.req_cs = 4'b0001;
        wait_busy(cnt);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_cs_async",  BB'(bus.mem_cs),   0);
        chk("t6_no_ack",    BB'(bus.resp_ack), 0);
        bus.req_cs = 4'b1000;
        bus.req_addr[3*AW +: AW] = 12'h3C0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_regrant_cs",   BB'(bus.mem_cs),   1);
        chk("t6_regrant_id",   BB'(bus.grant_id), 3);
        chk("t6_regrant_addr", BB'(bus.mem_addr), 12'h3C0);
        pulse_ack(1, mk_block(32'h3333_0000));
        chk("t6_resp_ack", BB'(bus.resp_ack), 4'b1000);
        bus.req_cs = '0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
